fifo_pop_scheduler: RTL and testbench

Controller that shares one downstream consumer between NUM_Q parallel FIFO instances. It configures their almost-full/almost-empty thresholds at init and pops them in round-robin order. It honours downstream back-pressure and realigns the FIFOs' one-cycle-late read data into a single valid-qualified output stream. It sits between the per-class FIFO bank and the next pipeline stage.

---
 rtl/fifo_pop_scheduler_pkg.sv | 22 ++
 rtl/fifo_pop_scheduler_if.sv | 26 ++
 rtl/fifo_pop_scheduler_rr_arbiter.sv | 41 ++++
 rtl/fifo_pop_scheduler.sv | 98 +++++++++
 tb/tb_fifo_pop_scheduler.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pop_scheduler_pkg.sv
// rtl/fifo_pop_scheduler_pkg.sv - shared state encodings, defaults and index-width helper
package fifo_ctrl_pkg;

    localparam int ST_W       = 3;
    localparam int DEF_UMB_AF = 12;
    localparam int DEF_UMB_AE = 2;

    typedef enum logic [ST_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_PAUSE  = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // Width of a queue index; never zero so a single-queue build still has a field.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_pop_scheduler_if.sv
// rtl/fifo_pop_scheduler_if.sv - FIFO-bank and downstream stream signals of the pop scheduler
interface fifo_pop_scheduler_if
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_Q  = 4,
    parameter int DATA_W = 6
);
    logic [NUM_Q-1:0]        pop;
    logic [NUM_Q-1:0]        fifo_empty;
    logic [NUM_Q-1:0]        fifo_error;
    logic [NUM_Q*DATA_W-1:0] fifo_data;
    logic                    dest_almost_full;
    logic [DATA_W-1:0]       data_out;
    logic                    valid_out;
    logic [idx_w(NUM_Q)-1:0] src_id;

    modport master (
        output pop, data_out, valid_out, src_id,
        input  fifo_empty, fifo_error, fifo_data, dest_almost_full
    );

    modport slave (
        input  pop, data_out, valid_out, src_id,
        output fifo_empty, fifo_error, fifo_data, dest_almost_full
    );
endinterface

// File: rtl/fifo_pop_scheduler_rr_arbiter.sv
// rtl/fifo_pop_scheduler_rr_arbiter.sv - round-robin arbiter owning the last-winner pointer
module rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_Q = 4,
    localparam int IW   = idx_w(NUM_Q)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM_Q-1:0] req,
    input  logic             en,
    output logic [NUM_Q-1:0] gnt,
    output logic [IW-1:0]    idx
);
    logic [IW-1:0] last;
    logic          hit;

    // Scan starts one past the previous winner so every requester is served in turn.
    always_comb begin
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        for (int k = 1; k <= NUM_Q; k++) begin
            if (!hit && req[(int'(last) + k) % NUM_Q]) begin
                hit = 1'b1;
                idx = IW'((int'(last) + k) % NUM_Q);
            end
        end
        if (en && hit) begin
            gnt[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= IW'(NUM_Q - 1);
        end else if (en && hit) begin
            last <= idx;
        end
    end
endmodule

// File: rtl/fifo_pop_scheduler.sv
// rtl/fifo_pop_scheduler.sv - round-robin pop scheduler sharing one consumer across a FIFO bank
module fifo_pop_scheduler
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_Q      = 4,
    parameter int DATA_W     = 6,
    parameter int CNT_W      = 4,
    parameter int UMB_AF_DEF = DEF_UMB_AF,
    parameter int UMB_AE_DEF = DEF_UMB_AE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [CNT_W-1:0]  umb_af_cfg,
    input  logic [CNT_W-1:0]  umb_ae_cfg,
    output logic [CNT_W-1:0]  umb_af_out,
    output logic [CNT_W-1:0]  umb_ae_out,
    output logic [ST_W-1:0]   state,
    output logic              error_out,
    fifo_pop_scheduler_if.master bus
);
    localparam int IW = idx_w(NUM_Q);

    state_t            state_q, state_d;
    logic              any_req;
    logic              arb_en;
    logic [IW-1:0]     win;
    logic              pop_d;
    logic [IW-1:0]     win_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_now;

    assign any_req = |(~bus.fifo_empty);
    // Back-pressure gates the strobe combinationally, ahead of the PAUSE transition.
    assign arb_en  = (state_q == ST_ACTIVE) && !bus.dest_almost_full;

    rr_arbiter #(.NUM_Q(NUM_Q)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (~bus.fifo_empty),
        .en    (arb_en),
        .gnt   (bus.pop),
        .idx   (win)
    );

    always_comb begin
        state_d = state_q;
        if (|bus.fifo_error) begin
            state_d = ST_ERROR;
        end else begin
            case (state_q)
                ST_RESET:  state_d = ST_INIT;
                ST_INIT:   if (!init) state_d = ST_IDLE;
                ST_IDLE: begin
                    if (init)         state_d = ST_INIT;
                    else if (any_req) state_d = bus.dest_almost_full ? ST_PAUSE : ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (bus.dest_almost_full) state_d = ST_PAUSE;
                    else if (!any_req)        state_d = ST_IDLE;
                end
                ST_PAUSE:  if (!bus.dest_almost_full) state_d = any_req ? ST_ACTIVE : ST_IDLE;
                ST_ERROR:  state_d = ST_ERROR;
                default:   state_d = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            umb_af_out <= CNT_W'(UMB_AF_DEF);
            umb_ae_out <= CNT_W'(UMB_AE_DEF);
            pop_d      <= 1'b0;
            win_d      <= '0;
            data_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT && init) begin
                umb_af_out <= umb_af_cfg;
                umb_ae_out <= umb_ae_cfg;
            end
            pop_d <= |bus.pop;
            if (|bus.pop) begin
                win_d <= win;
            end
            data_q <= data_now;
        end
    end

    // FIFO read data appears the cycle after its pop edge; otherwise hold the last word.
    assign data_now      = pop_d ? bus.fifo_data[int'(win_d)*DATA_W +: DATA_W] : data_q;
    assign bus.data_out  = data_now;
    assign bus.valid_out = pop_d;
    assign bus.src_id    = win_d;
    assign state         = state_q;
    assign error_out     = (state_q == ST_ERROR);
endmodule

// File: tb/tb_fifo_pop_scheduler.sv
// tb/tb_fifo_pop_scheduler.sv - directed table-driven bench for fifo_pop_scheduler
module tb_fifo_pop_scheduler;
    import fifo_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init = 1'b0;
    logic [3:0] af_cfg = '0;
    logic [3:0] ae_cfg = '0;
    logic [3:0] af_out, ae_out;
    logic [2:0] state;
    logic       error_out;

    fifo_pop_scheduler_if #(.NUM_Q(4), .DATA_W(6)) bus ();

    fifo_pop_scheduler #(.NUM_Q(4), .DATA_W(6), .CNT_W(4), .UMB_AF_DEF(12), .UMB_AE_DEF(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .umb_af_cfg (af_cfg),
        .umb_ae_cfg (ae_cfg),
        .umb_af_out (af_out),
        .umb_ae_out (ae_out),
        .state      (state),
        .error_out  (error_out),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cnt[4];
    int head[4];

    typedef struct {
        bit         rst;
        logic [3:0] fill;
        int         words;
        bit         af;
        logic [3:0] pop;
        logic [2:0] st;
        bit         vld;
        logic [1:0] src;
        logic [5:0] data;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [5:0] word(input int q, input int k);
        return 6'(q * 16 + k + 1);
    endfunction

    task automatic apply_empty();
        for (int i = 0; i < 4; i++) bus.fifo_empty[i] = (cnt[i] == 0);
    endtask

    // One clock: the FIFO model presents the popped word after the edge.
    task automatic tick();
        logic [3:0] p;
        p = bus.pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (p[i] && cnt[i] > 0) begin
                bus.fifo_data[i*6 +: 6] = word(i, head[i]);
                head[i]++;
                cnt[i]--;
            end
        end
        apply_empty();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            head[i] = 0;
        end
        bus.fifo_data = '0;
        apply_empty();
        reset = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end, expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            head[i] = 0;
        end
        bus.fifo_error = '0;
        bus.dest_almost_full = 1'b0;
        bus.fifo_data = '0;
        apply_empty();

        // rst fill words af | pop st vld src data
        tv.push_back('{0, 4'b0101, 2, 0, 4'b0000, 3'd2, 0, 2'd0, 6'd0});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b0001, 3'd3, 0, 2'd0, 6'd0});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b0100, 3'd3, 1, 2'd0, 6'd1});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b0001, 3'd3, 1, 2'd2, 6'd33});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b0100, 3'd3, 1, 2'd0, 6'd2});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b0000, 3'd3, 1, 2'd2, 6'd34});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b0000, 3'd2, 0, 2'd2, 6'd34});
        tv.push_back('{1, 4'b1111, 3, 0, 4'b0000, 3'd2, 0, 2'd0, 6'd0});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b0001, 3'd3, 0, 2'd0, 6'd0});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b0010, 3'd3, 1, 2'd0, 6'd1});
        tv.push_back('{0, 4'b0000, 0, 1, 4'b0000, 3'd3, 1, 2'd1, 6'd17});
        tv.push_back('{0, 4'b0000, 0, 1, 4'b0000, 3'd4, 0, 2'd1, 6'd17});
        tv.push_back('{0, 4'b0000, 0, 1, 4'b0000, 3'd4, 0, 2'd1, 6'd17});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b0000, 3'd4, 0, 2'd1, 6'd17});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b0100, 3'd3, 0, 2'd1, 6'd17});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b1000, 3'd3, 1, 2'd2, 6'd33});
        tv.push_back('{1, 4'b1000, 3, 0, 4'b0000, 3'd2, 0, 2'd0, 6'd0});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b1000, 3'd3, 0, 2'd0, 6'd0});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b1000, 3'd3, 1, 2'd3, 6'd49});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b1000, 3'd3, 1, 2'd3, 6'd50});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b0000, 3'd3, 1, 2'd3, 6'd51});
        tv.push_back('{0, 4'b1001, 1, 0, 4'b0000, 3'd2, 0, 2'd3, 6'd51});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b0001, 3'd3, 0, 2'd3, 6'd51});
        tv.push_back('{0, 4'b0000, 0, 0, 4'b1000, 3'd3, 1, 2'd0, 6'd1});

        // Reset values and threshold programming.
        repeat (2) @(posedge clk);
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pop", 32'(bus.pop), 32'd0);
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_src", 32'(bus.src_id), 32'd0);
        chk("rst_err", 32'(error_out), 32'd0);
        chk("rst_af", 32'(af_out), 32'd12);
        chk("rst_ae", 32'(ae_out), 32'd2);
        reset = 1'b0;
        init = 1'b1;
        af_cfg = 4'd10;
        ae_cfg = 4'd3;
        tick();
        chk("init_state", 32'(state), 32'd1);
        chk("init_af_not_yet", 32'(af_out), 32'd12);
        tick();
        tick();
        init = 1'b0;
        tick();
        chk("idle_state", 32'(state), 32'd2);
        chk("cfg_af", 32'(af_out), 32'd10);
        chk("cfg_ae", 32'(ae_out), 32'd3);
        chk("idle_pop", 32'(bus.pop), 32'd0);

        // Round-robin, back-pressure and wrap-around vectors.
        for (int r = 0; r < tv.size(); r++) begin
            if (tv[r].rst) do_reset();
            for (int i = 0; i < 4; i++) if (tv[r].fill[i]) cnt[i] += tv[r].words;
            bus.dest_almost_full = tv[r].af;
            apply_empty();
            #1;
            chk($sformatf("v%0d_pop", r), 32'(bus.pop), 32'(tv[r].pop));
            chk($sformatf("v%0d_state", r), 32'(state), 32'(tv[r].st));
            chk($sformatf("v%0d_valid", r), 32'(bus.valid_out), 32'(tv[r].vld));
            chk($sformatf("v%0d_src", r), 32'(bus.src_id), 32'(tv[r].src));
            chk($sformatf("v%0d_data", r), 32'(bus.data_out), 32'(tv[r].data));
            tick();
        end
        bus.dest_almost_full = 1'b0;

        // Error during ACTIVE is sticky and blocks pops.
        do_reset();
        cnt[0] = 3;
        cnt[1] = 3;
        apply_empty();
        tick();
        tick();
        chk("err_pre_state", 32'(state), 32'd3);
        bus.fifo_error = 4'b0010;
        tick();
        bus.fifo_error = '0;
        #1;
        chk("err_state", 32'(state), 32'd5);
        chk("err_out", 32'(error_out), 32'd1);
        chk("err_pop", 32'(bus.pop), 32'd0);
        tick();
        tick();
        chk("err_sticky_state", 32'(state), 32'd5);
        chk("err_sticky_out", 32'(error_out), 32'd1);
        chk("err_sticky_pop", 32'(bus.pop), 32'd0);

        // Asynchronous reset between a pop and its valid.
        do_reset();
        chk("ar_err_cleared", 32'(error_out), 32'd0);
        cnt[2] = 2;
        apply_empty();
        tick();
        chk("ar_pop", 32'(bus.pop), 32'b0100);
        reset = 1'b1;
        #1;
        chk("ar_pop_now", 32'(bus.pop), 32'd0);
        chk("ar_valid_now", 32'(bus.valid_out), 32'd0);
        chk("ar_state_now", 32'(state), 32'd0);
        reset = 1'b0;
        tick();
        chk("ar_valid_next", 32'(bus.valid_out), 32'd0);
        chk("ar_state_next", 32'(state), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
